dispatch_ctrl: RTL and testbench
================================

// Module: dispatch_ctrl
// PURPOSE
//  Dispatch scheduler between the 2-wide decode stage and the four issue queues
//  (ALU0, ALU1, AGU, BRU). Tracks free entries per IQ with credit counters and
//  accepts decoded slots strictly in order. Serialises privileged (PLV)
//  instructions: ROB drains first, then the instruction dispatches alone, then
//  dispatch blocks until it commits. Drives the decode-stage hold.
// PARAMETERS
//  IQ_DEPTH  8                          entries per issue queue (credit reset value)
//  CNT_W     $clog2(IQ_DEPTH+1)         credit counter width
// PORTS
//  clk           in   1        clock; all state updates on posedge
//  rst           in   1        synchronous reset, active-high
//  flush         in   1        pipeline flush; all IQs are emptied this cycle
//  slot0_vld     in   1        decode slot 0 holds an instruction (older)
//  slot0_iq      in   4        target IQ, one-hot {ALU0,ALU1,AGU,BRU}; 0000 = no IQ
//  slot0_plv     in   1        slot 0 is a privileged/serialising instruction
//  slot1_vld     in   1        decode slot 1 holds an instruction (younger)
//  slot1_iq      in   4        as slot0_iq
//  slot1_plv     in   1        as slot0_plv
//  iq_release    in   4        per-IQ: one entry freed this cycle (same bit order)
//  rob_empty     in   1        ROB holds no uncommitted instruction
//  serial_done   in   1        the dispatched PLV instruction has committed
//  dispatch0     out  1        slot 0 accepted this cycle (combinational)
//  dispatch1     out  1        slot 1 accepted this cycle (combinational)
//  hold_decode   out  1        a valid slot was not accepted; decode must hold
//  iq_free_cnt   out  4*CNT_W  registered credits, {ALU0,ALU1,AGU,BRU} MSB-first
//  serial_busy   out  1        FSM is in DRAIN or BLOCK
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state=RUN, every credit=IQ_DEPTH. While rst=1 the
//    combinational outputs are forced: dispatch0=dispatch1=0, hold_decode=0.
//  - A slot fits if its IQ's credit is >=1. iq=0000 needs no credit.
//    Both slots to the same IQ need >=2 credits.
//  - In order: dispatch1 requires dispatch0. slot1_vld with slot0_vld=0 is illegal;
//    slot1 is ignored. Upstream removes accepted slots and shifts slot1 into slot0.
//  - FSM RUN:
//    - slot0_plv=1: if rob_empty and it fits -> dispatch0 only, go to BLOCK.
//      If rob_empty and it does not fit -> stay RUN, nothing dispatches.
//      If !rob_empty -> nothing dispatches, go to DRAIN.
//    - Otherwise slot0 dispatches if it fits.
//    - slot1 dispatches if slot0 dispatched, slot1 fits, and slot1_plv=0.
//  - FSM DRAIN: no dispatch. When rob_empty=1 and slot0 fits -> dispatch0 only,
//    go to BLOCK. A flush is the only other exit.
//  - FSM BLOCK: no dispatch. serial_done=1 -> RUN at the next edge. Dispatch
//    resumes in the cycle after that.
//  - hold_decode = (slot0_vld & !dispatch0) | (slot1_vld & slot0_vld & !dispatch1).
//  - Credits, per IQ: next = min(cnt - disp_n + release, IQ_DEPTH), where
//    disp_n is 0..2.
//    - Release in the same cycle as a dispatch is not bypassed; it is visible
//      only from the next cycle.
//    - A release at cnt=IQ_DEPTH saturates (no wrap).
//    - A dispatch at cnt=0 cannot occur by construction.
//  - flush (priority below rst, above all else): dispatch0=dispatch1=0 and
//    hold_decode=0 this cycle; next state=RUN; all credits=IQ_DEPTH.
//    A serial_done or iq_release in the same cycle is ignored.
// TESTING
//  1 Reset, both slots iq=1000 plv=0 -> dispatch0=dispatch1=1, hold=0;
//    next cycle ALU0 credit=6, others=8.
//  2 ALU0 credit=1, both slots iq=1000 -> dispatch0=1, dispatch1=0, hold=1;
//    next cycle credit=0; iq_release=1000 -> credit=1 one cycle later.
//  3 AGU credit=8, one AGU dispatch + iq_release=0010 same cycle -> AGU credit
//    stays 8 (saturates, no overflow to 9/wrap).
//  4 slot0_plv=1 iq=0010, rob_empty=0 for 3 cycles -> DRAIN, hold=1, no dispatch;
//    rob_empty=1 -> dispatch0 alone, BLOCK; serial_done -> RUN.
//  5 Slot0 normal, slot1_plv=1 in RUN -> dispatch0=1, dispatch1=0, hold=1;
//    PLV then serialised as in test 4.
//  6 flush while BLOCK with credits {2,5,0,7} -> no dispatch that cycle; next
//    state RUN, credits all 8. Repeat with rst instead of flush: same result.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// rtl/dispatch_ctrl.sv - in-order 2-wide dispatch with IQ credits and PLV serialisation
module dispatch_ctrl #(
  parameter int IQ_DEPTH = 8,
  parameter int CNT_W    = $clog2(IQ_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               slot0_vld,
  input  logic [3:0]         slot0_iq,
  input  logic               slot0_plv,
  input  logic               slot1_vld,
  input  logic [3:0]         slot1_iq,
  input  logic               slot1_plv,
  input  logic [3:0]         iq_release,
  input  logic               rob_empty,
  input  logic               serial_done,
  output logic               dispatch0,
  output logic               dispatch1,
  output logic               hold_decode,
  output logic [4*CNT_W-1:0] iq_free_cnt,
  output logic               serial_busy
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    BLOCK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(IQ_DEPTH);

  // Credit index i matches iq bit i: 3=ALU0, 2=ALU1, 1=AGU, 0=BRU
  state_t           state;
  logic [CNT_W-1:0] cnt     [4];
  logic [CNT_W-1:0] cnt_nxt [4];
  logic [CNT_W:0]   sum     [4];
  logic [3:0]       has1;
  logic [3:0]       has2;
  logic             fit0;
  logic             fit1;

  // Per-IQ availability and slot fit checks; slot1 must fit on top of slot0
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      has1[i] = (cnt[i] >= CNT_W'(1));
      has2[i] = (cnt[i] >= CNT_W'(2));
    end
    fit0 = &(~slot0_iq | has1);
    fit1 = &(~slot1_iq | (slot0_iq & has2) | (~slot0_iq & has1));
  end

  // Dispatch decision and decode hold, suppressed during reset and flush
  always_comb begin
    dispatch0   = 1'b0;
    dispatch1   = 1'b0;
    hold_decode = 1'b0;
    if (!rst && !flush) begin
      case (state)
        RUN: begin
          if (slot0_vld) begin
            if (slot0_plv) begin
              dispatch0 = rob_empty & fit0;
            end else begin
              dispatch0 = fit0;
              dispatch1 = fit0 & slot1_vld & ~slot1_plv & fit1;
            end
          end
        end
        DRAIN:   dispatch0 = slot0_vld & rob_empty & fit0;
        default: ;
      endcase
      hold_decode = (slot0_vld & ~dispatch0) | (slot1_vld & slot0_vld & ~dispatch1);
    end
  end

  // Next credit: consume dispatches, add releases, saturate at the queue depth
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sum[i] = {1'b0, cnt[i]}
             - (CNT_W + 1)'(dispatch0 & slot0_iq[i])
             - (CNT_W + 1)'(dispatch1 & slot1_iq[i])
             + (CNT_W + 1)'(iq_release[i]);
      cnt_nxt[i] = (sum[i] > DEPTH_W) ? DEPTH_C : sum[i][CNT_W-1:0];
    end
  end

  // Credit registers; reset and flush refill every queue
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst || flush) cnt[i] <= DEPTH_C;
      else              cnt[i] <= cnt_nxt[i];
    end
  end

  // Serialisation FSM with registered busy flag
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state       <= RUN;
      serial_busy <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (slot0_vld && slot0_plv) begin
            if (!rob_empty) begin
              state       <= DRAIN;
              serial_busy <= 1'b1;
            end else if (fit0) begin
              state       <= BLOCK;
              serial_busy <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (dispatch0) begin
            state       <= BLOCK;
            serial_busy <= 1'b1;
          end
        end
        BLOCK: begin
          if (serial_done) begin
            state       <= RUN;
            serial_busy <= 1'b0;
          end
        end
        default: begin
          state       <= RUN;
          serial_busy <= 1'b0;
        end
      endcase
    end
  end

  assign iq_free_cnt = {cnt[3], cnt[2], cnt[1], cnt[0]};

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb/tb_dispatch_ctrl.sv - directed self-checking bench for dispatch_ctrl
module tb_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        slot0_vld, slot0_plv, slot1_vld, slot1_plv;
  logic [3:0]  slot0_iq, slot1_iq, iq_release;
  logic        rob_empty, serial_done;
  logic        dispatch0, dispatch1, hold_decode, serial_busy;
  logic [15:0] iq_free_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  dispatch_ctrl #(.IQ_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .slot0_vld(slot0_vld), .slot0_iq(slot0_iq), .slot0_plv(slot0_plv),
    .slot1_vld(slot1_vld), .slot1_iq(slot1_iq), .slot1_plv(slot1_plv),
    .iq_release(iq_release), .rob_empty(rob_empty), .serial_done(serial_done),
    .dispatch0(dispatch0), .dispatch1(dispatch1), .hold_decode(hold_decode),
    .iq_free_cnt(iq_free_cnt), .serial_busy(serial_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [3:0] i0, input logic p0,
                       input logic v1, input logic [3:0] i1, input logic p1);
    slot0_vld = v0; slot0_iq = i0; slot0_plv = p0;
    slot1_vld = v1; slot1_iq = i1; slot1_plv = p1;
  endtask

  task automatic idle();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    iq_release = 4'b0000; serial_done = 1'b0; flush = 1'b0; rob_empty = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b0);
    #1;
    tests_run++; if (dispatch0 !== 1'b0) begin tests_failed++; $display("FAIL rst_d0 got %b exp 0", dispatch0); end
    tests_run++; if (dispatch1 !== 1'b0) begin tests_failed++; $display("FAIL rst_d1 got %b exp 0", dispatch1); end
    tests_run++; if (hold_decode !== 1'b0) begin tests_failed++; $display("FAIL rst_hold got %b exp 0", hold_decode); end
    step();
    rst = 1'b0;
    idle();
    #1;
    tests_run++; if (iq_free_cnt !== 16'h8888) begin tests_failed++; $display("FAIL rst_cnt got %h exp 8888", iq_free_cnt); end
    tests_run++; if (serial_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy got %b exp 0", serial_busy); end
  endtask

  task automatic test_dual_dispatch();
    drive(1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b0);
    #1;
    tests_run++; if ({dispatch0, dispatch1, hold_decode} !== 3'b110) begin tests_failed++; $display("FAIL dual_out got %b exp 110", {dispatch0, dispatch1, hold_decode}); end
    step();
    tests_run++; if (iq_free_cnt !== 16'h6888) begin tests_failed++; $display("FAIL dual_cnt got %h exp 6888", iq_free_cnt); end
  endtask

  task automatic test_credit_limit();
    drive(1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b0);
    step();
    step();
    drive(1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0);
    step();
    tests_run++; if (iq_free_cnt !== 16'h1888) begin tests_failed++; $display("FAIL lim_pre got %h exp 1888", iq_free_cnt); end
    drive(1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b0);
    #1;
    tests_run++; if ({dispatch0, dispatch1, hold_decode} !== 3'b101) begin tests_failed++; $display("FAIL lim_one got %b exp 101", {dispatch0, dispatch1, hold_decode}); end
    step();
    tests_run++; if (iq_free_cnt !== 16'h0888) begin tests_failed++; $display("FAIL lim_zero got %h exp 0888", iq_free_cnt); end
    drive(1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0);
    iq_release = 4'b1000;
    #1;
    tests_run++; if ({dispatch0, hold_decode} !== 2'b01) begin tests_failed++; $display("FAIL lim_nobypass got %b exp 01", {dispatch0, hold_decode}); end
    step();
    idle();
    #1;
    tests_run++; if (iq_free_cnt !== 16'h1888) begin tests_failed++; $display("FAIL lim_release got %h exp 1888", iq_free_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0);
    iq_release = 4'b0010;
    #1;
    tests_run++; if (dispatch0 !== 1'b1) begin tests_failed++; $display("FAIL sat_d0 got %b exp 1", dispatch0); end
    step();
    tests_run++; if (iq_free_cnt !== 16'h8888) begin tests_failed++; $display("FAIL sat_disp_rel got %h exp 8888", iq_free_cnt); end
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    step();
    tests_run++; if (iq_free_cnt !== 16'h8888) begin tests_failed++; $display("FAIL sat_rel_full got %h exp 8888", iq_free_cnt); end
    drive(1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0);
    #1;
    tests_run++; if ({dispatch0, dispatch1} !== 2'b11) begin tests_failed++; $display("FAIL sat_pair got %b exp 11", {dispatch0, dispatch1}); end
    step();
    idle();
    tests_run++; if (iq_free_cnt !== 16'h8878) begin tests_failed++; $display("FAIL sat_pair_rel got %h exp 8878", iq_free_cnt); end
  endtask

  task automatic test_plv_drain();
    do_reset();
    rob_empty = 1'b0;
    drive(1'b1, 4'b0010, 1'b1, 1'b1, 4'b1000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++; if ({dispatch0, dispatch1, hold_decode} !== 3'b001) begin tests_failed++; $display("FAIL drain_wait%0d got %b exp 001", k, {dispatch0, dispatch1, hold_decode}); end
      step();
      tests_run++; if (serial_busy !== 1'b1) begin tests_failed++; $display("FAIL drain_busy%0d got %b exp 1", k, serial_busy); end
    end
    rob_empty = 1'b1;
    #1;
    tests_run++; if ({dispatch0, dispatch1, hold_decode} !== 3'b101) begin tests_failed++; $display("FAIL drain_go got %b exp 101", {dispatch0, dispatch1, hold_decode}); end
    step();
    tests_run++; if ({serial_busy, iq_free_cnt} !== {1'b1, 16'h8878}) begin tests_failed++; $display("FAIL drain_block got %b/%h exp 1/8878", serial_busy, iq_free_cnt); end
    drive(1'b1, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0);
    #1;
    tests_run++; if ({dispatch0, hold_decode} !== 2'b01) begin tests_failed++; $display("FAIL block_hold got %b exp 01", {dispatch0, hold_decode}); end
    serial_done = 1'b1;
    #1;
    tests_run++; if (dispatch0 !== 1'b0) begin tests_failed++; $display("FAIL block_done_d0 got %b exp 0", dispatch0); end
    step();
    serial_done = 1'b0;
    #1;
    tests_run++; if ({serial_busy, dispatch0} !== 2'b01) begin tests_failed++; $display("FAIL block_resume got %b exp 01", {serial_busy, dispatch0}); end
    step();
    idle();
    tests_run++; if (iq_free_cnt !== 16'h7878) begin tests_failed++; $display("FAIL block_resume_cnt got %h exp 7878", iq_free_cnt); end
  endtask

  task automatic test_plv_slot1();
    do_reset();
    rob_empty = 1'b0;
    drive(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0001, 1'b1);
    #1;
    tests_run++; if ({dispatch0, dispatch1, hold_decode} !== 3'b101) begin tests_failed++; $display("FAIL s1plv_out got %b exp 101", {dispatch0, dispatch1, hold_decode}); end
    step();
    tests_run++; if ({serial_busy, iq_free_cnt} !== {1'b0, 16'h8788}) begin tests_failed++; $display("FAIL s1plv_cnt got %b/%h exp 0/8788", serial_busy, iq_free_cnt); end
    drive(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0);
    #1;
    tests_run++; if ({dispatch0, hold_decode} !== 2'b01) begin tests_failed++; $display("FAIL s1plv_wait got %b exp 01", {dispatch0, hold_decode}); end
    step();
    rob_empty = 1'b1;
    #1;
    tests_run++; if ({serial_busy, dispatch0, hold_decode} !== 3'b110) begin tests_failed++; $display("FAIL s1plv_go got %b exp 110", {serial_busy, dispatch0, hold_decode}); end
    step();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    tests_run++; if ({serial_busy, iq_free_cnt} !== {1'b1, 16'h8787}) begin tests_failed++; $display("FAIL s1plv_block got %b/%h exp 1/8787", serial_busy, iq_free_cnt); end
    serial_done = 1'b1;
    step();
    idle();
    tests_run++; if (serial_busy !== 1'b0) begin tests_failed++; $display("FAIL s1plv_run got %b exp 0", serial_busy); end
  endtask

  task automatic setup_block();
    do_reset();
    for (int k = 0; k < 3; k++) begin drive(1'b1, 4'b1000, 1'b0, 1'b1, 4'b1000, 1'b0); step(); end
    drive(1'b1, 4'b0100, 1'b0, 1'b1, 4'b0100, 1'b0); step();
    drive(1'b1, 4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0); step();
    for (int k = 0; k < 4; k++) begin drive(1'b1, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b0); step(); end
    drive(1'b1, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0);
    #1;
    tests_run++; if ({dispatch0, hold_decode} !== 2'b01) begin tests_failed++; $display("FAIL agu_empty got %b exp 01", {dispatch0, hold_decode}); end
    drive(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0);
    step();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0);
    tests_run++; if ({serial_busy, iq_free_cnt} !== {1'b1, 16'h2507}) begin tests_failed++; $display("FAIL setup_block got %b/%h exp 1/2507", serial_busy, iq_free_cnt); end
  endtask

  task automatic test_flush_rst();
    for (int pass = 0; pass < 2; pass++) begin
      setup_block();
      if (pass == 0) flush = 1'b1; else rst = 1'b1;
      drive(1'b1, 4'b1000, 1'b0, 1'b1, 4'b0100, 1'b0);
      serial_done = 1'b1;
      iq_release = 4'b1111;
      #1;
      tests_run++; if ({dispatch0, dispatch1, hold_decode} !== 3'b000) begin tests_failed++; $display("FAIL clr%0d_out got %b exp 000", pass, {dispatch0, dispatch1, hold_decode}); end
      step();
      rst = 1'b0;
      idle();
      tests_run++; if ({serial_busy, iq_free_cnt} !== {1'b0, 16'h8888}) begin tests_failed++; $display("FAIL clr%0d_state got %b/%h exp 0/8888", pass, serial_busy, iq_free_cnt); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    test_reset();
    test_dual_dispatch();
    test_credit_limit();
    test_saturate();
    test_plv_drain();
    test_plv_slot1();
    test_flush_rst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
